// File: rtl/pe_mac_seq.sv
// rtl/pe_mac_seq.sv - per-PE MAC loop sequencer (optional perf counters under PE_MAC_SEQ_PERF_CNT_EN)
module pe_mac_seq #(
  parameter int IPADSIZE = 12,
  parameter int WPADSIZE = 48,
  parameter int PPADSIZE = 64,
  parameter int MACLAT   = 2,
  localparam int IPAW = $clog2(IPADSIZE),
  localparam int WPAW = $clog2(WPADSIZE),
  localparam int PPAW = $clog2(PPADSIZE)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            stall,
  input  logic            dval,
  input  logic [4:0]      cfg_pm,
  input  logic [IPAW:0]   cfg_ipad_size,
  input  logic [6:0]      cfg_tw,
  input  logic [IPAW:0]   cfg_upix,
  output logic [IPAW-1:0] ipad_raddr,
  output logic [WPAW-1:0] wpad_raddr,
  output logic [PPAW-1:0] ppad_raddr,
  output logic [PPAW-1:0] ppad_waddr,
  output logic            ppad_write,
  output logic            ss_valid,
  output logic            ss_fstpix,
  output logic            ss_lstpix,
  output logic            busy,
  output logic            done
`ifdef PE_MAC_SEQ_PERF_CNT_EN
  ,
  output logic [15:0]     perf_busy_cyc,
  output logic [15:0]     perf_stall_cyc
`endif
);

  localparam int DW = (MACLAT > 1) ? $clog2(MACLAT) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(MACLAT - 1);
  localparam logic [IPAW:0] IPAD_DEPTH = (IPAW+1)'(IPADSIZE);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
  state_t state, state_nxt;

  logic [4:0]      pm_q, m_q;
  logic [IPAW:0]   isz_q, upix_q, k_q, base_q;
  logic [6:0]      tw_q, x_q;
  logic [WPAW-1:0] wrow_q;
  logic [PPAW-1:0] pbase_q;
  logic [DW-1:0]   drain_q;
  logic [PPAW-1:0] wb_addr [MACLAT];
  logic [MACLAT-1:0] wb_val;

  logic adv, start_ok, last_m, last_k, last_x;
  logic [IPAW:0] upix_red, isum, iaddr_nxt, bsum, base_nxt;

  assign adv      = (state == S_RUN) & ~stall & dval;
  assign start_ok = start & (state == S_IDLE);
  assign last_m   = (m_q == pm_q - 5'd1);
  assign last_k   = (k_q == isz_q - (IPAW+1)'(1));
  assign last_x   = (x_q == tw_q - 7'd1);
  assign busy     = (state != S_IDLE);

  // Reduce the column stride into [0, IPADSIZE) once at start; the field can hold up to ~4x depth
  always_comb begin
    upix_red = cfg_upix;
    for (int i = 0; i < 3; i++) begin
      if (upix_red >= IPAD_DEPTH) upix_red = upix_red - IPAD_DEPTH;
    end
  end

  // Modulo-depth wrap for the window read address and the next column base
  always_comb begin
    isum      = base_q + k_q;
    iaddr_nxt = (isum >= IPAD_DEPTH) ? isum - IPAD_DEPTH : isum;
    bsum      = base_q + upix_q;
    base_nxt  = (bsum >= IPAD_DEPTH) ? bsum - IPAD_DEPTH : bsum;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: RUN until the last issue, DRAIN for MACLAT advancing cycles, one DONE cycle
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (adv && last_m && last_k && last_x) state_nxt = S_DRAIN;
      S_DRAIN: if (!stall && drain_q == DRAIN_LAST) state_nxt = S_DONE;
      S_DONE:  if (!stall) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Config latch and x/k/m loop counters with incremental address bases
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pm_q <= '0; isz_q <= '0; tw_q <= '0; upix_q <= '0;
      x_q <= '0; k_q <= '0; m_q <= '0;
      base_q <= '0; wrow_q <= '0; pbase_q <= '0;
    end else if (start_ok) begin
      pm_q <= cfg_pm; isz_q <= cfg_ipad_size; tw_q <= cfg_tw; upix_q <= upix_red;
      x_q <= '0; k_q <= '0; m_q <= '0;
      base_q <= '0; wrow_q <= '0; pbase_q <= '0;
    end else if (adv) begin
      if (last_m) begin
        m_q    <= '0;
        wrow_q <= '0;
        if (last_k) begin
          k_q     <= '0;
          x_q     <= x_q + 7'd1;
          base_q  <= base_nxt;
          pbase_q <= pbase_q + PPAW'(pm_q);
        end else begin
          k_q <= k_q + (IPAW+1)'(1);
        end
      end else begin
        m_q    <= m_q + 5'd1;
        wrow_q <= wrow_q + WPAW'(isz_q);
      end
    end
  end

  // Issue register: addresses and shift-stage bits, frozen while stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ss_valid <= 1'b0; ss_fstpix <= 1'b0; ss_lstpix <= 1'b0;
      ipad_raddr <= '0; wpad_raddr <= '0; ppad_raddr <= '0;
    end else if (!stall) begin
      ss_valid  <= adv;
      ss_fstpix <= adv & (k_q == '0);
      ss_lstpix <= adv & last_k;
      if (adv) begin
        ipad_raddr <= iaddr_nxt[IPAW-1:0];
        wpad_raddr <= wrow_q + WPAW'(k_q);
        ppad_raddr <= pbase_q + PPAW'(m_q);
      end
    end
  end

  // Write-back delay line; keeps shifting in DRAIN so the final issues reach the psum pad
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_val <= '0;
      for (int i = 0; i < MACLAT; i++) wb_addr[i] <= '0;
    end else if (!stall) begin
      wb_val[0]  <= ss_valid;
      wb_addr[0] <= ppad_raddr;
      for (int i = 1; i < MACLAT; i++) begin
        wb_val[i]  <= wb_val[i-1];
        wb_addr[i] <= wb_addr[i-1];
      end
    end
  end

  assign ppad_waddr = wb_addr[MACLAT-1];
  assign ppad_write = wb_val[MACLAT-1];

  // Drain cycle counter and the registered completion pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drain_q <= '0;
      done    <= 1'b0;
    end else begin
      done <= (state == S_DONE) & ~stall;
      if (state != S_DRAIN) drain_q <= '0;
      else if (!stall)      drain_q <= drain_q + DW'(1);
    end
  end

`ifdef PE_MAC_SEQ_PERF_CNT_EN
  // Saturating activity counters, cleared when a sequence is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_busy_cyc  <= '0;
      perf_stall_cyc <= '0;
    end else if (start_ok) begin
      perf_busy_cyc  <= '0;
      perf_stall_cyc <= '0;
    end else begin
      if ((state == S_RUN || state == S_DRAIN) && perf_busy_cyc != 16'hFFFF)
        perf_busy_cyc <= perf_busy_cyc + 16'd1;
      if (state == S_RUN && !adv && perf_stall_cyc != 16'hFFFF)
        perf_stall_cyc <= perf_stall_cyc + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pe_mac_seq.sv
// tb/tb_pe_mac_seq.sv - randomized self-checking bench for pe_mac_seq
module tb_pe_mac_seq;

  localparam int IPADSIZE = 12;
  localparam int WPADSIZE = 48;
  localparam int PPADSIZE = 64;
  localparam int MACLAT   = 2;
  localparam int IPAW = $clog2(IPADSIZE);
  localparam int WPAW = $clog2(WPADSIZE);
  localparam int PPAW = $clog2(PPADSIZE);

  logic clk = 1'b0;
  logic rst, start, stall, dval;
  logic [4:0]      cfg_pm;
  logic [IPAW:0]   cfg_ipad_size, cfg_upix;
  logic [6:0]      cfg_tw;
  logic [IPAW-1:0] ipad_raddr;
  logic [WPAW-1:0] wpad_raddr;
  logic [PPAW-1:0] ppad_raddr, ppad_waddr;
  logic ppad_write, ss_valid, ss_fstpix, ss_lstpix, busy, done;
`ifdef PE_MAC_SEQ_PERF_CNT_EN
  logic [15:0] perf_busy_cyc, perf_stall_cyc;
`endif

  pe_mac_seq #(.IPADSIZE(IPADSIZE), .WPADSIZE(WPADSIZE), .PPADSIZE(PPADSIZE), .MACLAT(MACLAT)) dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall), .dval(dval),
    .cfg_pm(cfg_pm), .cfg_ipad_size(cfg_ipad_size), .cfg_tw(cfg_tw), .cfg_upix(cfg_upix),
    .ipad_raddr(ipad_raddr), .wpad_raddr(wpad_raddr), .ppad_raddr(ppad_raddr),
    .ppad_waddr(ppad_waddr), .ppad_write(ppad_write),
    .ss_valid(ss_valid), .ss_fstpix(ss_fstpix), .ss_lstpix(ss_lstpix),
    .busy(busy), .done(done)
`ifdef PE_MAC_SEQ_PERF_CNT_EN
    , .perf_busy_cyc(perf_busy_cyc), .perf_stall_cyc(perf_stall_cyc)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { int i; int w; int p; bit f; bit l; } iss_t;
  iss_t iq[$];
  int   wq[$];

  int checks = 0;
  int errors = 0;
  int iss_cnt = 0, done_cnt = 0, cyc = 0;
  int busy_rise_cyc = 0, done_cyc = 0;
  logic busy_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: the plain loop nest with closed-form addresses
  task automatic build_model(input int pm, input int isz, input int tw, input int upix);
    iss_t e;
    iq.delete();
    wq.delete();
    for (int x = 0; x < tw; x++)
      for (int k = 0; k < isz; k++)
        for (int m = 0; m < pm; m++) begin
          e.i = (x * upix + k) % IPADSIZE;
          e.w = (m * isz + k) % (1 << WPAW);
          e.p = (x * pm + m) % (1 << PPAW);
          e.f = (k == 0);
          e.l = (k == isz - 1);
          iq.push_back(e);
          wq.push_back(e.p);
        end
  endtask

  // Compare process: an issue/write is consumed on any cycle it is presented without stall
  always @(negedge clk) begin
    iss_t e;
    cyc <= cyc + 1;
    if (!rst) begin
      if (busy && !busy_prev) busy_rise_cyc <= cyc;
      if (done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
      if (ss_valid && !stall) begin
        iss_cnt <= iss_cnt + 1;
        if (iq.size() == 0) chk("unexpected_issue", 1, 0);
        else begin
          e = iq.pop_front();
          chk("ipad_raddr", 32'(ipad_raddr), e.i);
          chk("wpad_raddr", 32'(wpad_raddr), e.w);
          chk("ppad_raddr", 32'(ppad_raddr), e.p);
          chk("ss_fstpix", 32'(ss_fstpix), 32'(e.f));
          chk("ss_lstpix", 32'(ss_lstpix), 32'(e.l));
        end
      end
      if (ppad_write && !stall) begin
        if (wq.size() == 0) chk("unexpected_write", 1, 0);
        else chk("ppad_waddr", 32'(ppad_waddr), wq.pop_front());
      end
    end
    busy_prev <= busy & ~rst;
  end

  task automatic drive_cfg(input int pm, input int isz, input int tw, input int upix);
    cfg_pm        = 5'(pm);
    cfg_ipad_size = (IPAW+1)'(isz);
    cfg_tw        = 7'(tw);
    cfg_upix      = (IPAW+1)'(upix);
  endtask

  // mode 0: clean; 1: stall x3 at issue 4 + dval low x2 at issue 9; 2: random; 3: stall x3 only
  task automatic run_seq(input int pm, input int isz, input int tw, input int upix,
                         input int mode, input bit restart, input bit chk_lat, input string tag);
    int d0, i0, n, sleft, dleft;
    bit sflag, dflag, rflag, tmo;
    build_model(pm, isz, tw, upix);
    d0 = done_cnt; i0 = iss_cnt;
    n = 0; sleft = 0; dleft = 0; sflag = 0; dflag = 0; rflag = 0; tmo = 0;
    @(posedge clk); #1;
    drive_cfg(pm, isz, tw, upix);
    start = 1'b1; stall = 1'b0; dval = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (done_cnt == d0) begin
      if ((mode == 1 || mode == 3) && !sflag && iss_cnt - i0 == 3) begin sleft = 3; sflag = 1; end
      if (mode == 1 && !dflag && iss_cnt - i0 == 8) begin dleft = 2; dflag = 1; end
      if (mode == 2) begin
        stall = ($urandom_range(0, 3) == 0);
        dval  = ($urandom_range(0, 3) != 0);
      end else begin
        stall = (sleft > 0);
        dval  = (dleft == 0);
        if (sleft > 0) sleft--;
        if (dleft > 0) dleft--;
      end
      if (restart && !rflag && iss_cnt - i0 == 2) begin start = 1'b1; rflag = 1; end
      else start = 1'b0;
      @(posedge clk); #1;
      n++;
      if (n > 5000) begin tmo = 1; break; end
    end
    stall = 1'b0; dval = 1'b1; start = 1'b0;
    if (tmo) begin
      chk({tag, "_timeout"}, 1, 0);
      rst = 1'b1; #2; rst = 1'b0;
      iq.delete(); wq.delete();
    end else begin
      chk({tag, "_issues_left"}, iq.size(), 0);
      chk({tag, "_writes_left"}, wq.size(), 0);
      chk({tag, "_done_pulses"}, done_cnt - d0, 1);
      if (chk_lat) chk({tag, "_done_latency"}, done_cyc - busy_rise_cyc, pm * isz * tw + MACLAT + 1);
    end
  endtask

  task automatic reset_mid();
    int i0, d0, n;
    build_model(2, 3, 2, 1);
    i0 = iss_cnt; d0 = done_cnt; n = 0;
    @(posedge clk); #1;
    drive_cfg(2, 3, 2, 1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (iss_cnt - i0 < 4 && n < 100) begin @(posedge clk); #1; n++; end
    chk("rst_reached_issue5", 32'(ss_valid), 1);
    #2; rst = 1'b1; #1;
    iq.delete(); wq.delete();
    chk("rst_ss_valid", 32'(ss_valid), 0);
    chk("rst_ppad_write", 32'(ppad_write), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ipad_raddr", 32'(ipad_raddr), 0);
    chk("rst_wpad_raddr", 32'(wpad_raddr), 0);
    chk("rst_ppad_raddr", 32'(ppad_raddr), 0);
    chk("rst_ppad_waddr", 32'(ppad_waddr), 0);
    @(posedge clk); #1; rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("rst_no_done", done_cnt - d0, 0);
    chk("rst_idle", 32'(busy), 0);
  endtask

  int lit_i [12] = '{0, 0, 1, 1, 2, 2, 1, 1, 2, 2, 3, 3};
  int lit_w [12] = '{0, 3, 1, 4, 2, 5, 0, 3, 1, 4, 2, 5};
  int lit_p [12] = '{0, 1, 0, 1, 0, 1, 2, 3, 2, 3, 2, 3};

  initial begin
    int pm, isz, tw, upix;
    rst = 1'b1; start = 1'b0; stall = 1'b0; dval = 1'b1;
    drive_cfg(1, 1, 1, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ss_valid", 32'(ss_valid), 0);
    chk("reset_ss_fstpix", 32'(ss_fstpix), 0);
    chk("reset_ss_lstpix", 32'(ss_lstpix), 0);
    chk("reset_ppad_write", 32'(ppad_write), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_ipad_raddr", 32'(ipad_raddr), 0);
    chk("reset_ppad_waddr", 32'(ppad_waddr), 0);
    rst = 1'b0;

    build_model(2, 3, 2, 1);
    for (int n = 0; n < 12; n++) begin
      chk("model_basic_i", iq[n].i, lit_i[n]);
      chk("model_basic_w", iq[n].w, lit_w[n]);
      chk("model_basic_p", iq[n].p, lit_p[n]);
      chk("model_basic_f", 32'(iq[n].f), 32'(n == 0 || n == 1 || n == 6 || n == 7));
      chk("model_basic_l", 32'(iq[n].l), 32'(n == 4 || n == 5 || n == 10 || n == 11));
    end
    build_model(1, 4, 4, 4);
    for (int n = 0; n < 4; n++) chk("model_wrap_x3", iq[12 + n].i, n);
    iq.delete(); wq.delete();
    repeat (2) @(posedge clk);

    run_seq(2, 3, 2, 1, 0, 0, 1, "basic");
    run_seq(2, 3, 2, 1, 0, 0, 1, "back_to_back");
    run_seq(1, 4, 4, 4, 0, 0, 1, "wrap");
    run_seq(2, 3, 2, 1, 1, 0, 0, "stall_dval");
    run_seq(2, 3, 2, 1, 3, 0, 0, "perf");
`ifdef PE_MAC_SEQ_PERF_CNT_EN
    chk("perf_stall_cyc", 32'(perf_stall_cyc), 3);
    chk("perf_busy_cyc", 32'(perf_busy_cyc), 12 + 3 + MACLAT);
`endif
    run_seq(2, 3, 2, 1, 0, 1, 1, "restart_ignored");
    reset_mid();
    run_seq(2, 3, 2, 1, 0, 0, 1, "after_reset");
    run_seq(1, 1, 1, 0, 0, 0, 1, "single");
    run_seq(4, 12, 16, 31, 0, 0, 1, "max_upix");
    run_seq(31, 1, 2, 5, 2, 0, 0, "wide_pm");

    for (int r = 0; r < 20; r++) begin
      pm   = $urandom_range(1, 8);
      isz  = $urandom_range(1, (48 / pm < 12) ? 48 / pm : 12);
      tw   = $urandom_range(1, 64 / pm);
      upix = $urandom_range(0, 31);
      run_seq(pm, isz, tw, upix, (r % 3 == 0) ? 0 : 2, (r % 5 == 1), (r % 3 == 0), "random");
    end

    repeat (5) @(posedge clk);
    #1;
    chk("final_idle", 32'(busy), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pe_mac_seq.md
Name: pe_mac_seq

Overview:
- Per-PE loop sequencer for one configuration. It walks the Tw-column × ipad_size-element × Pm-filter loop nest.
- Each cycle it issues ipad/wpad/ppad read addresses and the shift-stage control bits (valid, fstpix, lstpix) to the MAC datapath.
- It generates the delayed psum write-back address and reports done.
- It sits between the PE's Conf/Inst decode and the scratchpads plus Aunit/shift stage.

Parameters:
- IPADSIZE, 12, input scratchpad depth; IPAW = $clog2(IPADSIZE)
- WPADSIZE, 48, weight scratchpad depth; WPAW = $clog2(WPADSIZE)
- PPADSIZE, 64, psum scratchpad depth; PPAW = $clog2(PPADSIZE)
- MACLAT, 2, cycles from issue to psum write-back (≥1)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  pulse; latches config and begins sequence (ignored unless IDLE)
- stall  in  1  freezes counters and pipeline
- dval  in  1  input pixels available; issue advances only when high
- cfg_pm  in  5  filters (≥1)
- cfg_ipad_size  in  IPAW+1  elements per window, pch*R (≥1)
- cfg_tw  in  7  output columns (≥1)
- cfg_upix  in  IPAW+1  window advance per column, U*pch
- ipad_raddr  out  IPAW  input read address
- wpad_raddr  out  WPAW  weight read address
- ppad_raddr  out  PPAW  psum read address
- ppad_waddr  out  PPAW  psum write address (MACLAT-delayed)
- ppad_write  out  1  psum write strobe
- ss_valid  out  1  issue valid
- ss_fstpix  out  1  k==0: psum initializes to 0
- ss_lstpix  out  1  k==ipad_size-1
- busy  out  1  not IDLE
- done  out  1  one-cycle pulse at completion

Behaviour:
- Clock and reset: single clock clk. rst is asynchronous, active-high. Reset → IDLE. All outputs 0 and all counters 0.
- States:
  - IDLE: start → RUN; config latched on this edge.
  - RUN: issue loop; after the last issue → DRAIN.
  - DRAIN: waits MACLAT advancing cycles → DONE.
  - DONE: done=1 for one cycle → IDLE.
- adv = (state==RUN) & ~stall & dval. ss_valid = adv, registered together with the addresses; outputs are valid the cycle after counters are evaluated.
- Loop order: x (0..tw-1) outer, k (0..ipad_size-1) middle, m (0..pm-1) inner.
- Address generation:
  - ipad_raddr = (base + k) mod IPADSIZE. base += cfg_upix mod IPADSIZE when x increments. Wrap uses compare-subtract, no divider.
  - wpad_raddr = m*ipad_size + k, computed incrementally: wrow += ipad_size per m, cleared when m wraps.
  - ppad_raddr = x*pm + m, computed incrementally with a pbase register.
- Write-back pipeline: MACLAT-deep shift register carries {ppad_raddr, ss_valid}. ppad_waddr/ppad_write are the tap outputs. The pipeline advances when ~stall (not gated by dval), so it flushes in DRAIN.
- stall holds every register including the pipeline. stall in DONE delays done.
- start while busy is ignored. done and start in the same cycle: the new start is accepted only in IDLE.
- rst mid-run aborts immediately. No write strobe follows reset.
- Config widths are caller-guaranteed: pm*tw ≤ PPADSIZE and pm*ipad_size ≤ WPADSIZE. Overflow wraps modulo 2^width; no checking.

Optional Feature:
- Macro: PE_MAC_SEQ_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_busy_cyc [15:0] and perf_stall_cyc [15:0].
  - perf_busy_cyc counts cycles in RUN/DRAIN.
  - perf_stall_cyc counts RUN cycles with ~adv.
  - Both counters clear on start and saturate at 16'hFFFF.
- Undefined: these ports and counters do not exist.

Test Plan:
- Basic sequence: pm=2, ipad_size=3, tw=2, upix=1, dval=1, no stall.
  - (i,w,p) sequence: (0,0,0)(0,3,1)(1,1,0)(1,4,1)(2,2,0)(2,5,1)(1,0,2)(1,3,3)(2,1,2)(2,4,3)(3,2,2)(3,5,3).
  - fstpix on issues 1,2,7,8; lstpix on issues 5,6,11,12.
  - done occurs 12+MACLAT+1 cycles after the first issue.
- Wrap-around: ipad_size=4, upix=4, tw=4, pm=1. Column bases are 0,4,8,0, so ipad_raddr for x=3 is 0,1,2,3.
- Stall and dval: in the basic config, hold stall for 3 cycles at issue 4, then drop dval for 2 cycles at issue 9.
  - Same 12-issue sequence with no duplicates or skips.
  - ppad_write count is 12; the waddr sequence matches raddr delayed.
- Reset mid-run: assert rst at issue 5. All outputs are 0 in the same cycle; no ppad_write after reset. A subsequent start reruns from (0,0,0).
- Start while busy: a second start at issue 3 is ignored and exactly one done pulse is produced. A start one cycle after done begins a new sequence.
- Perf (macro defined): basic config with 3 stall cycles gives perf_stall_cyc=3 and perf_busy_cyc=12+3+MACLAT.
